// File: rtl/mw_wb_stage_pkg.sv
// Shared constants and W-stage decode for the MIPS memory-to-writeback stage.
package mw_wb_stage_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LW     = 6'b100011;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_MOVZ = 6'b001010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // REGIMM rt field selectors for the linking branches
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    localparam logic [4:0] LINK_REG = 5'd31;

    // Byte lane of a word selected by the low address bits
    typedef enum logic [1:0] {
        LANE_B0 = 2'd0,
        LANE_B1 = 2'd1,
        LANE_B2 = 2'd2,
        LANE_B3 = 2'd3
    } byte_lane_e;

    // W-stage control bundle
    typedef struct packed {
        logic regwrite;  // instruction class writes the register file
        logic memtoreg;  // full word from data memory
        logic lb;        // sign-extended byte from data memory
        logic link;      // writes PC+8
        logic link31;    // destination forced to $31
        logic cond_en;   // write gated by cond_W
    } wb_ctrl_t;

    function automatic wb_ctrl_t decode_wb(input logic [31:0] instr);
        wb_ctrl_t   c;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        op = instr[31:26];
        fn = instr[5:0];
        rt = instr[20:16];
        c  = '0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU, FN_SUBU, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
                    FN_NOR, FN_SLT, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV:
                        c.regwrite = 1'b1;
                    FN_JALR: begin
                        c.regwrite = 1'b1;
                        c.link     = 1'b1;
                    end
                    FN_MOVZ: begin
                        c.regwrite = 1'b1;
                        c.cond_en  = 1'b1;
                    end
                    default: c = '0;
                endcase
            end
            OP_REGIMM: begin
                if (rt == RT_BGEZAL || rt == RT_BLTZAL) begin
                    c.regwrite = 1'b1;
                    c.link     = 1'b1;
                    c.link31   = 1'b1;
                    c.cond_en  = 1'b1;
                end
            end
            OP_JAL: begin
                c.regwrite = 1'b1;
                c.link     = 1'b1;
                c.link31   = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                c.regwrite = 1'b1;
            OP_LW: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            OP_LB: begin
                c.regwrite = 1'b1;
                c.lb       = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mw_wb_stage_if.sv
// M-stage inputs and W-stage results of the memory-to-writeback stage.
interface mw_wb_stage_if;
    logic        valid_M;
    logic [31:0] instr_M;
    logic [31:0] pc8_M;
    logic [31:0] alu_M;
    logic [31:0] dm_rdata_M;
    logic        cond_M;
    logic [31:0] instr_W;
    logic        valid_W;
    logic        reg_we_W;
    logic [4:0]  reg_waddr_W;
    logic [31:0] reg_wdata_W;
    logic [31:0] retire_cnt;

    modport master (
        output valid_M, instr_M, pc8_M, alu_M, dm_rdata_M, cond_M,
        input  instr_W, valid_W, reg_we_W, reg_waddr_W, reg_wdata_W, retire_cnt
    );

    modport slave (
        input  valid_M, instr_M, pc8_M, alu_M, dm_rdata_M, cond_M,
        output instr_W, valid_W, reg_we_W, reg_waddr_W, reg_wdata_W, retire_cnt
    );
endinterface

// File: rtl/mw_wb_stage_lb_extend.sv
// Byte-lane select and sign extension for lb writeback data.
module wb_lb_extend
    import mw_wb_stage_pkg::*;
(
    input  logic [31:0] word,
    input  byte_lane_e  lane,
    output logic [31:0] ext
);
    logic [7:0] lanes [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = word[gi*8 +: 8];
        end
    endgenerate

    logic [7:0] sel_byte;

    // Pick the addressed byte and replicate its sign bit
    always_comb begin
        sel_byte = lanes[lane];
        ext      = {{24{sel_byte[7]}}, sel_byte};
    end
endmodule

// File: rtl/mw_wb_stage.sv
// M/W pipeline register, writeback decode/mux and retired-instruction counter.
module mw_wb_stage
    import mw_wb_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    mw_wb_stage_if.slave  bus
);
    logic        valid_reg;
    logic [31:0] instr_reg;
    logic [31:0] pc8_reg;
    logic [31:0] alu_reg;
    logic [31:0] dm_reg;
    logic        cond_reg;
    logic [31:0] cnt_reg;

    // Capture the M-stage slot every cycle; a bubble carries instr 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
            pc8_reg   <= '0;
            alu_reg   <= '0;
            dm_reg    <= '0;
            cond_reg  <= 1'b0;
        end else begin
            valid_reg <= bus.valid_M;
            instr_reg <= bus.valid_M ? bus.instr_M : 32'd0;
            pc8_reg   <= bus.pc8_M;
            alu_reg   <= bus.alu_M;
            dm_reg    <= bus.dm_rdata_M;
            cond_reg  <= bus.cond_M;
        end
    end

    // Count each valid W instruction as it leaves the stage (wraps naturally)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (valid_reg) begin
            cnt_reg <= cnt_reg + 32'd1;
        end
    end

    wb_ctrl_t    ctrl;
    logic [31:0] lb_data;
    logic [4:0]  waddr_next;
    logic [31:0] wdata_next;
    logic        we_next;

    wb_lb_extend u_lb_extend (
        .word (dm_reg),
        .lane (byte_lane_e'(alu_reg[1:0])),
        .ext  (lb_data)
    );

    // Destination, data priority (link > word load > byte load > ALU) and gated enable
    always_comb begin
        ctrl = decode_wb(instr_reg);
        if (ctrl.link31)
            waddr_next = LINK_REG;
        else if (instr_reg[31:26] == OP_RTYPE)
            waddr_next = instr_reg[15:11];
        else
            waddr_next = instr_reg[20:16];

        if (ctrl.link)
            wdata_next = pc8_reg;
        else if (ctrl.memtoreg)
            wdata_next = dm_reg;
        else if (ctrl.lb)
            wdata_next = lb_data;
        else
            wdata_next = alu_reg;

        we_next = valid_reg & ctrl.regwrite & (waddr_next != 5'd0)
                & (ctrl.cond_en ? cond_reg : 1'b1);
    end

    assign bus.instr_W     = instr_reg;
    assign bus.valid_W     = valid_reg;
    assign bus.reg_we_W    = we_next;
    assign bus.reg_waddr_W = waddr_next;
    assign bus.reg_wdata_W = wdata_next;
    assign bus.retire_cnt  = cnt_reg;
endmodule

// File: doc/mw_wb_stage.md
# mw_wb_stage

Memory-to-writeback pipeline register plus writeback datapath for the five-stage MIPS core. Captures the M-stage instruction and its results on each clock, decodes W-stage control from the registered instruction, and produces the final register-file write (enable, address, data), which also feeds W→D/E forwarding. Keeps a retired-instruction counter for bench checking.

## Interface
- (no parameters; data width fixed at 32, register address at 5)
- clk  in  1  core clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid_M  in  1  M-stage slot holds a real instruction (0 = bubble)
- instr_M  in  32  M-stage instruction word
- pc8_M  in  32  PC+8 of the M-stage instruction (link value)
- alu_M  in  32  ALU result / memory address from M
- dm_rdata_M  in  32  data-memory word read in M
- cond_M  in  1  conditional-write qualifier: movz rt==0, bgezal/bltzal taken
- instr_W  out  32  registered instruction
- valid_W  out  1  registered valid
- reg_we_W  out  1  register-file write enable
- reg_waddr_W  out  5  register-file write address
- reg_wdata_W  out  32  register-file write data
- retire_cnt  out  32  count of valid instructions retired

## Operation
- Pipeline register: on each rising edge captures valid_M, instr_M, pc8_M, alu_M, dm_rdata_M, cond_M. No stall/hold; W never stalls.
- Bubble: valid_M=0 captures instr 0 and valid 0; all other fields captured unchanged.
- Decode (from registered instr_W): memtoreg (lw 100011), lb (100000), jal (000011), jalr (funct 001001), bgezal (REGIMM rt 10001), bltzal (REGIMM rt 10000), movz (funct 001010), regwrite for addu/subu/add/sub/and/or/xor/nor/slt/sll/srl/sra/sllv/srlv/jr-class funct, addi/addiu/slti/andi/ori/xori/lui, lw, lb, jal, REGIMM-link. sw, sb, branches, unknown: regwrite 0.
- Address: jal, bgezal, bltzal → 31; jalr and R-type → instr_W[15:11]; I-type → instr_W[20:16].
- Data priority: link (jal/jalr/bgezal/bltzal) → pc8_W; memtoreg → dm_rdata_W; lb → sign-extended byte selected by alu_W[1:0] (0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]); else alu_W.
- Enable: reg_we_W = valid_W & regwrite & (waddr≠0) & qualifier, qualifier = cond_W for movz/bgezal/bltzal, else 1.
- retire_cnt: +1 on each rising edge where valid_W=1; wraps 0xFFFFFFFF→0.

## Timing
- Reset (async assert): instr_W=0, valid_W=0, all captured data 0, retire_cnt=0 → reg_we_W=0, reg_waddr_W=0, reg_wdata_W=0 immediately.
- Deassertion takes effect at the next rising edge; capture resumes that edge.
- Latency: M inputs at edge N visible on all W outputs after edge N; reg_we/waddr/wdata are combinational from registers, same cycle as instr_W.
- Register file writes on the following edge; internal forwarding is the register file's concern.
- Reset mid-stream: in-flight W instruction dropped, not counted.
- Bubble after valid: counter stops incrementing that cycle; write enable 0.
- Write to $0 never asserts enable, including jalr rd=0 and addu rd=0.
- bgezal/bltzal not taken (cond=0): no write, still counted as retired.

## Structure
- Shared package: opcode/funct/REGIMM-rt constants, link register index 31, byte-lane select encoding.
- One sub-module natural: wb_lb_extend (byte select + sign extension, combinational); pipeline register, decode, muxes, counter stay in top.

## Test plan
- Reset low mid-run with valid lw in W → outputs 0, retire_cnt 0 without clock edge.
- addu $3 ← alu 0x0000_1234 → next cycle reg_we 1, waddr 3, wdata 0x1234, retire_cnt +1.
- lb, dm_rdata 0x80FF_7F01, alu[1:0]=0,1,2,3 → wdata 0x1, 0x7F, 0xFFFF_FFFF, 0xFFFF_FF80.
- jal pc8 0x3008 → waddr 31, wdata 0x3008; bgezal cond 0 → reg_we 0, count +1.
- movz rd 5 cond 1 → write alu_W; cond 0 → reg_we 0; addiu rt=0 → reg_we 0.
- Alternate valid_M/bubble 10 cycles, 5 valid → retire_cnt 5; preload via 2^32 retires → wraps to 0.
